// File: rtl/calc1_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc1_drv_pkg
// Description : Shared constants, state encoding and operation record for the
//               calc1 request driver.
// Revision    : 1.0 - initial release
// ============================================================================
package calc1_drv_pkg;

  // calc1 command codes
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  // calc1 response codes
  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_OK   = 2'd1;
  localparam logic [1:0] RSP_ERR  = 2'd2;

  // Driver FSM state encoding
  typedef logic [2:0] drv_state_t;
  localparam drv_state_t ST_IDLE  = 3'd0;
  localparam drv_state_t ST_SEND1 = 3'd1;
  localparam drv_state_t ST_SEND2 = 3'd2;
  localparam drv_state_t ST_WAIT  = 3'd3;
  localparam drv_state_t ST_DONE  = 3'd4;

  // One host operation: command plus both operands (68 bits)
  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] data1;
    logic [31:0] data2;
  } calc1_op_t;

endpackage
`default_nettype wire

// File: rtl/calc1_op_fifo.sv
`default_nettype none
// ============================================================================
// Module      : calc1_op_fifo
// Description : Circular operation queue with extra-MSB pointers for full /
//               empty detection. Reset flushes by clearing the pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module calc1_op_fifo
  import calc1_drv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  calc1_op_t wr_op,
  output calc1_op_t rd_op,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  calc1_op_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_op   = mem[rd_ptr[AW-1:0]];

  // Pointer update; full is registered state, so a pop never frees space for a same-cycle push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_op;
  end

endmodule
`default_nettype wire

// File: rtl/calc1_req_driver.sv
`default_nettype none
// ============================================================================
// Module      : calc1_req_driver
// Description : Host-side calc1 initiator. Queues host operations, serialises
//               each onto the two-cycle request protocol, waits for a response
//               or timeout and reports the outcome as a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module calc1_req_driver
  import calc1_drv_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        host_valid,
  input  logic [3:0]  host_cmd,
  input  logic [31:0] host_data1,
  input  logic [31:0] host_data2,
  output logic        host_ready,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  input  logic [1:0]  out_resp_in,
  input  logic [31:0] out_data_in,
  output logic        rsp_valid,
  output logic [1:0]  rsp_code,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        stray_resp
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  drv_state_t    state;
  logic [CW-1:0] cnt;
  logic [31:0]   issue_data2;
  logic [1:0]    cap_code;
  logic [31:0]   cap_data;
  logic          cap_timeout;

  calc1_op_t     wr_op;
  calc1_op_t     head_op;
  logic          q_full;
  logic          q_empty;
  logic          q_push;
  logic          q_pop;

  assign host_ready = !q_full;
  // NOP commands are handshaken but never stored
  assign q_push     = host_valid && host_ready && (host_cmd != CMD_NOP);
  assign q_pop      = (state == ST_IDLE) && !q_empty;
  assign wr_op      = '{cmd: host_cmd, data1: host_data1, data2: host_data2};
  assign busy       = (state != ST_IDLE) || !q_empty;

  calc1_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (c_clk),
    .rst   (reset),
    .push  (q_push),
    .pop   (q_pop),
    .wr_op (wr_op),
    .rd_op (head_op),
    .full  (q_full),
    .empty (q_empty)
  );

  // Request sequencing FSM; request outputs are loaded one edge early so they line up with the state
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      issue_data2  <= '0;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      cap_code     <= '0;
      cap_data     <= '0;
      cap_timeout  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_code     <= '0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            issue_data2  <= head_op.data2;
            req_cmd_out  <= head_op.cmd;
            req_data_out <= head_op.data1;
            state        <= ST_SEND1;
          end
        end
        ST_SEND1: begin
          req_cmd_out  <= CMD_NOP;
          req_data_out <= issue_data2;
          state        <= ST_SEND2;
        end
        ST_SEND2: begin
          req_data_out <= '0;
          cnt          <= '0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          // A response on the last counted cycle still wins over the timeout
          if (out_resp_in != RSP_NONE) begin
            cap_code    <= out_resp_in;
            cap_data    <= out_data_in;
            cap_timeout <= 1'b0;
            state       <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            cap_code    <= RSP_NONE;
            cap_data    <= '0;
            cap_timeout <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_DONE: begin
          rsp_valid   <= 1'b1;
          rsp_code    <= cap_code;
          rsp_data    <= cap_data;
          rsp_timeout <= cap_timeout;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flag for any response seen while no request is awaiting one
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      stray_resp <= 1'b0;
    end else if ((out_resp_in != RSP_NONE) && (state != ST_WAIT)) begin
      stray_resp <= 1'b1;
    end
  end

endmodule
`default_nettype wire
